seg_scan_ctrl: RTL and testbench

Scan controller for the 8-digit seven-segment display. It sequences the `BCD_control` mux by driving its `refreshcounter` and supplies the packed digit values the mux selects from. It drives the active-low anodes with dead-time blanking between digits to stop ghosting. Score updates from game logic go into a double buffer and are committed only at frame boundaries, so a displayed number never tears mid-scan.

---
 rtl/seg_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: slot timing, anode drive with dead-time blanking,
// and frame-synchronous double-buffered digit commit. Optional macro: SEG_LZB_EN (leading-zero blanking).
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] digits_in,
    input  logic        load,
    input  logic [7:0]  digit_en,
    output logic [31:0] shown,
    output logic [2:0]  refreshcounter,
    output logic [7:0]  AN,
    output logic        load_ack,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYCLES);

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    state_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]   idx_q, idx_d;
    logic [31:0]  shown_q, shown_d;
    logic [31:0]  pending_q, pending_d;
    logic         pending_v_q, pending_v_d;
    logic [7:0]   an_q, an_d;
    logic         load_ack_q, load_ack_d;
    logic         frame_done_q, frame_done_d;
    logic         boundary;
    logic         visible;

`ifdef SEG_LZB_EN
    logic [7:0] lz_ok;

    // A position is eligible only if it or some more significant digit is non-zero.
    always_comb begin
        lz_ok = 8'hFF;
        for (int k = 1; k < 8; k++) begin
            lz_ok[k] = |(shown_q >> (4 * k));
        end
    end

    assign visible = digit_en[idx_d] & lz_ok[idx_d];
`else
    assign visible = digit_en[idx_d];
`endif

    always_comb begin
        boundary = (cnt_q == CNT_LAST) && (idx_q == 3'd7);

        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end

        state_d = state_q;
        if (cnt_q == CNT_LAST) begin
            state_d = ST_BLANK;
        end else if (cnt_d == CNT_ON) begin
            state_d = ST_ON;
        end

        shown_d     = shown_q;
        pending_d   = pending_q;
        pending_v_d = pending_v_q;
        load_ack_d  = 1'b0;
        if (boundary) begin
            // A load landing on the boundary itself skips the buffer.
            if (load) begin
                shown_d     = digits_in;
                pending_v_d = 1'b0;
                load_ack_d  = 1'b1;
            end else if (pending_v_q) begin
                shown_d     = pending_q;
                pending_v_d = 1'b0;
                load_ack_d  = 1'b1;
            end
        end else if (load) begin
            pending_d   = digits_in;
            pending_v_d = 1'b1;
        end

        // Outputs are registered, so they are computed from the next-cycle slot position.
        an_d = 8'hFF;
        if (state_d == ST_ON && visible) begin
            an_d = ~(8'b1 << idx_d);
        end
        frame_done_d = (cnt_d == CNT_LAST) && (idx_d == 3'd7);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shown_q      <= 32'd0;
            pending_q    <= 32'd0;
            pending_v_q  <= 1'b0;
            an_q         <= 8'hFF;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shown_q      <= shown_d;
            pending_q    <= pending_d;
            pending_v_q  <= pending_v_d;
            an_q         <= an_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign shown          = shown_q;
    assign refreshcounter = idx_q;
    assign AN             = an_q;
    assign load_ack       = load_ack_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-indexed reference model plus directed load/enable/reset scenarios.
module tb_seg_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = 8 * RD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] digits_in = 32'd0;
    logic        load = 1'b0;
    logic [7:0]  digit_en = 8'hFF;
    logic [31:0] shown;
    logic [2:0]  refreshcounter;
    logic [7:0]  AN;
    logic        load_ack;
    logic        frame_done;

    seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .load(load),
        .digit_en(digit_en), .shown(shown), .refreshcounter(refreshcounter),
        .AN(AN), .load_ack(load_ack), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          t = 0;
    int          acks = 0;
    logic [7:0]  an_low_seen = 8'h00;
    logic [31:0] m_shown, m_pend;
    logic        m_pv, m_ack;
    logic [7:0]  m_en_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_an();
        int         pos;
        int         cnt;
        logic       vis;
        logic [7:0] one;
        one = 8'b1;
        cnt = t % RD;
        pos = (t / RD) % 8;
        if (cnt < BC) return 8'hFF;
        vis = m_en_prev[pos];
`ifdef SEG_LZB_EN
        if (pos != 0 && (m_shown >> (4 * pos)) == 0) vis = 1'b0;
`endif
        return vis ? ~(one << pos) : 8'hFF;
    endfunction

    task automatic compare_all();
        chk("an", {24'd0, AN}, {24'd0, exp_an()});
        chk("refreshcounter", {29'd0, refreshcounter}, ((t / RD) % 8));
        chk("frame_done", {31'd0, frame_done}, {31'd0, (t % FR) == FR - 1});
        chk("load_ack", {31'd0, load_ack}, {31'd0, m_ack});
        chk("shown", shown, m_shown);
    endtask

    task automatic model_clear();
        m_shown = 32'd0; m_pend = 32'd0; m_pv = 1'b0; m_ack = 1'b0;
        m_en_prev = digit_en; t = 0; acks = 0; an_low_seen = 8'h00;
    endtask

    // One clock: update the model from the inputs seen at the edge, then check at the falling edge.
    task automatic step();
        @(posedge clk);
        m_ack = 1'b0;
        if ((t % FR) == FR - 1) begin
            if (load) begin
                m_shown = digits_in; m_pv = 1'b0; m_ack = 1'b1;
            end else if (m_pv) begin
                m_shown = m_pend; m_pv = 1'b0; m_ack = 1'b1;
            end
        end else if (load) begin
            m_pend = digits_in; m_pv = 1'b1;
        end
        m_en_prev = digit_en;
        t++;
        @(negedge clk);
        compare_all();
        if (load_ack) acks++;
        if (t >= FR) an_low_seen = an_low_seen | ~AN;
    endtask

    task automatic run_to(input int n);
        while (t < n) step();
    endtask

    task automatic pulse_load(input logic [31:0] v);
        load = 1'b1; digits_in = v;
        step();
        load = 1'b0;
    endtask

    // Entered at a falling edge; asserts reset immediately, releases at a later falling edge.
    task automatic do_reset();
        load = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_an", {24'd0, AN}, 32'hFF);
        chk("rst_rc", {29'd0, refreshcounter}, 32'd0);
        chk("rst_shown", shown, 32'd0);
        chk("rst_ack", {31'd0, load_ack}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        compare_all();
    endtask

    initial begin
        @(negedge clk);
        // Basic scan and single load committed at the first boundary.
        do_reset();
        run_to(1);
        chk("an_c1", {24'd0, AN}, 32'hFF);
        run_to(2);
        chk("an_c2", {24'd0, AN}, 32'hFE);
        run_to(8);
        chk("an_c8", {24'd0, AN}, 32'hFF);
        run_to(10);
`ifndef SEG_LZB_EN
        chk("an_c10", {24'd0, AN}, 32'hFD);
`endif
        pulse_load(32'h0000_0123);
        run_to(63);
        chk("fd_c63", {31'd0, frame_done}, 32'd1);
        chk("shown_c63", shown, 32'd0);
        step();
        chk("shown_c64", shown, 32'h0000_0123);
        chk("ack_c64", {31'd0, load_ack}, 32'd1);
        step();
        chk("ack_c65", {31'd0, load_ack}, 32'd0);
        run_to(130);

        // Two loads before commit: latest wins, single ack.
        do_reset();
        run_to(5);
        pulse_load(32'h11);
        run_to(20);
        pulse_load(32'h22);
        run_to(70);
        chk("two_loads_acks", acks, 32'd1);
        chk("two_loads_shown", shown, 32'h22);

        // Load exactly on the boundary cycle.
        do_reset();
        run_to(63);
        pulse_load(32'h9);
        chk("bypass_shown", shown, 32'h9);
        chk("bypass_ack", {31'd0, load_ack}, 32'd1);
        run_to(70);

        // Masked position 2.
        do_reset();
        pulse_load(32'h8765_4321);
        digit_en = 8'b1111_1011;
        run_to(20);
        chk("mask_slot2", {24'd0, AN}, 32'hFF);
        run_to(26);
`ifndef SEG_LZB_EN
        chk("slot3_on", {24'd0, AN}, 32'hF7);
`endif
        run_to(150);
        digit_en = 8'hFF;
        step();

`ifdef SEG_LZB_EN
        // Leading-zero blanking: only the two low positions light.
        do_reset();
        pulse_load(32'h0000_0045);
        run_to(2 * FR + 2);
        chk("lzb_low_only", {24'd0, an_low_seen & 8'hFC}, 32'd0);
        chk("lzb_both_lit", {24'd0, an_low_seen & 8'h03}, 32'h3);
`endif

        // Reset mid-scan discards a pending load.
        do_reset();
        run_to(20);
        pulse_load(32'h77);
        run_to(30);
        do_reset();
        run_to(2);
        chk("post_rst_an", {24'd0, AN}, 32'hFE);
        run_to(70);
        chk("post_rst_shown", shown, 32'd0);
        chk("post_rst_acks", acks, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
